// File: rtl/serial_pkg.sv
// Shared definitions for the serial link: frame state encoding and the
// default word width used by both the serializer and the matching receiver.
package serial_pkg;

  // Frame states; PAR is only entered when the parity bit is enabled.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
  } ser_state_t;

  localparam int SER_WIDTH_DEFAULT = 7;

endpackage

// File: rtl/ser_bit_counter.sv
// Bit counter for one serial frame. cnt holds the number of bits already
// placed on the line, so cnt==1 while bit 0 is showing. tc flags the final
// bit of the frame (TERM bits long) and is decoded from the register only.
module ser_bit_counter #(
  parameter int WIDTH = 7,
  parameter int TERM  = 7,
  parameter int CW    = $clog2(WIDTH + 2)
) (
  input  logic          clk,
  input  logic          res,
  input  logic          clr,
  input  logic          load1,
  input  logic          inc,
  output logic [CW-1:0] cnt,
  output logic          tc
);

  localparam logic [CW-1:0] TERM_C = CW'(TERM);

  // Load-to-1 starts a new frame and wins over clear, so back-to-back frames never pass through 0.
  always_ff @(posedge clk) begin
    if (res) begin
      cnt <= '0;
    end else if (load1) begin
      cnt <= CW'(1);
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = (cnt == TERM_C);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter, LSB first, one bit per clk, with a
// valid/ready load handshake that allows back-to-back frames.
// Optional even-parity bit after the data bits: define PISO_SERIALIZER_PARITY_EN.
module piso_serializer
  import serial_pkg::*;
#(
  parameter int WIDTH = SER_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             res,
  input  logic [WIDTH-1:0] d,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             last,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 2);
`ifdef PISO_SERIALIZER_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif
  localparam logic [CW-1:0] DATA_LAST = CW'(WIDTH);

  ser_state_t       state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic             accept;
  logic             cnt_inc;
  logic             cnt_clr;
`ifdef PISO_SERIALIZER_PARITY_EN
  logic             par_bit;
`endif

  // Ready depends only on registered state so there is no path from load_valid.
  assign load_ready = (state == IDLE) | last;
  assign accept     = load_valid & load_ready;
  assign busy       = (state != IDLE);
  assign cnt_inc    = busy & ~last;
  assign cnt_clr    = last & ~accept;

  ser_bit_counter #(
    .WIDTH(WIDTH),
    .TERM (FRAME_LEN),
    .CW   (CW)
  ) u_cnt (
    .clk  (clk),
    .res  (res),
    .clr  (cnt_clr),
    .load1(accept),
    .inc  (cnt_inc),
    .cnt  (cnt),
    .tc   (last)
  );

  // Frame FSM and shift register; an accept always restarts with bit 0, even on the final-bit cycle.
  always_ff @(posedge clk) begin
    if (res) begin
      state      <= IDLE;
      shreg      <= '0;
      sout       <= 1'b0;
      sout_valid <= 1'b0;
`ifdef PISO_SERIALIZER_PARITY_EN
      par_bit    <= 1'b0;
`endif
    end else if (accept) begin
      state      <= SHIFT;
      shreg      <= d >> 1;
      sout       <= d[0];
      sout_valid <= 1'b1;
`ifdef PISO_SERIALIZER_PARITY_EN
      par_bit    <= ^d;
`endif
    end else begin
      case (state)
        SHIFT: begin
          if (cnt < DATA_LAST) begin
            sout  <= shreg[0];
            shreg <= shreg >> 1;
          end else begin
`ifdef PISO_SERIALIZER_PARITY_EN
            state <= PAR;
            sout  <= par_bit;
`else
            state      <= IDLE;
            sout       <= 1'b0;
            sout_valid <= 1'b0;
`endif
          end
        end
        PAR: begin
          state      <= IDLE;
          sout       <= 1'b0;
          sout_valid <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          sout       <= 1'b0;
          sout_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer (WIDTH=7). Expected bit streams are
// queued when a word is issued; a monitor pops them whenever sout_valid is high.
module tb_piso_serializer;

  localparam int W = 7;
`ifdef PISO_SERIALIZER_PARITY_EN
  localparam bit PAR_ON = 1'b1;
  localparam int FL     = 8;
`else
  localparam bit PAR_ON = 1'b0;
  localparam int FL     = 7;
`endif

  logic         clk = 1'b0;
  logic         res;
  logic [W-1:0] d;
  logic         load_valid;
  logic         load_ready;
  logic         sout;
  logic         sout_valid;
  logic         last;
  logic         busy;

  typedef struct {
    logic bitval;
    logic lastval;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   mon_en  = 1'b0;
  int   run_len = 0;
  int   last_run = 0;

  piso_serializer #(.WIDTH(W)) dut (
    .clk       (clk),
    .res       (res),
    .d         (d),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .sout      (sout),
    .sout_valid(sout_valid),
    .last      (last),
    .busy      (busy)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Queue one frame; seq is written bit 0 first, left to right, as it appears on sout.
  task automatic pushFrame(input bit [0:6] seq, input bit p);
    for (int i = 0; i < W; i++) begin
      exp_t e;
      e.bitval  = seq[i];
      e.lastval = (!PAR_ON && i == W - 1);
      sb.push_back(e);
    end
    if (PAR_ON) begin
      exp_t e;
      e.bitval  = p;
      e.lastval = 1'b1;
      sb.push_back(e);
    end
  endtask

  task automatic applyStimulus(input logic [W-1:0] word);
    d          = word;
    load_valid = 1'b1;
    @(posedge clk);
    #1;
    load_valid = 1'b0;
  endtask

  // Wait for the current frame run to end, then check its length.
  task automatic waitIdle(input string name, input int exp_len);
    bit seen_idle = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (sout_valid !== 1'b1) begin
        seen_idle = 1'b1;
        break;
      end
    end
    #1;
    if (!seen_idle) begin
      n_tests++;
      n_fail++;
      $display("[TB] FAIL %s_timeout: got busy, expected idle within 100 cycles", name);
    end else begin
      checkOutput({name, "_len"}, last_run, exp_len);
      checkOutput({name, "_busy"}, busy, 0);
    end
  endtask

  // Monitor: compare every valid bit against the scoreboard and track run lengths.
  always @(negedge clk) begin
    if (mon_en) begin
      if (sout_valid === 1'b1) begin
        run_len++;
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("[TB] FAIL extra_bit: got sout=%0b, expected no valid bit at %0t", sout, $time);
        end else begin
          exp_t e;
          e = sb.pop_front();
          checkOutput("sout", sout, e.bitval);
          checkOutput("last", last, e.lastval);
        end
      end else begin
        if (run_len != 0) begin
          last_run = run_len;
          run_len  = 0;
        end
        checkOutput("idle_outs", {sout, last}, 0);
      end
    end
  end

  // Global watchdog so the bench can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  idx;
    bit  got;
    res        = 1'b1;
    load_valid = 1'b0;
    d          = '0;

    // Reset held for two cycles
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst_valid", sout_valid, 0);
    checkOutput("rst_busy", busy, 0);
    @(posedge clk);
    #1;
    res    = 1'b0;
    mon_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("rst_outs", {sout, sout_valid, last, busy}, 4'b0000);
      checkOutput("rst_ready", load_ready, 1);
    end

    // Single word
    pushFrame(7'b1110000, 1'b1);
    applyStimulus(7'b0000111);
    waitIdle("single", FL);
    checkOutput("single_ready", load_ready, 1);

    // Back-to-back frames, load_valid held high
    pushFrame(7'b1010101, 1'b0);
    pushFrame(7'b0001111, 1'b0);
    d          = 7'b1010101;
    load_valid = 1'b1;
    @(posedge clk);
    #1;
    d   = 7'b1111000;
    got = 1'b0;
    idx = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (load_ready === 1'b1) begin
        got = 1'b1;
        idx = i;
        break;
      end
    end
    checkOutput("b2b_ready_seen", got, 1);
    checkOutput("b2b_ready_cycle", idx, FL - 1);
    checkOutput("b2b_last_at_ready", last, 1);
    @(posedge clk);
    #1;
    load_valid = 1'b0;
    waitIdle("b2b", 2 * FL);

    // Load attempt while not ready is ignored
    pushFrame(7'b1100000, 1'b0);
    applyStimulus(7'b0000011);
    @(posedge clk);
    #1;
    checkOutput("ign_ready", load_ready, 0);
    d          = 7'b1111111;
    load_valid = 1'b1;
    @(posedge clk);
    #1;
    load_valid = 1'b0;
    waitIdle("ignored", FL);
    repeat (3) @(negedge clk);
    checkOutput("ign_queue", sb.size(), 0);

    // Reset during the third bit of a frame
    begin
      exp_t e;
      e.lastval = 1'b0;
      e.bitval = 1'b0; sb.push_back(e);
      e.bitval = 1'b1; sb.push_back(e);
      e.bitval = 1'b1; sb.push_back(e);
    end
    applyStimulus(7'b1100110);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    res = 1'b1;
    @(posedge clk);
    #1;
    res = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("midrst_outs", {sout, sout_valid, last, busy}, 4'b0000);
    checkOutput("midrst_ready", load_ready, 1);
    checkOutput("midrst_run", last_run, 3);
    checkOutput("midrst_queue", sb.size(), 0);
    pushFrame(7'b1000000, 1'b1);
    applyStimulus(7'b0000001);
    waitIdle("after_rst", FL);

    repeat (3) @(negedge clk);
    checkOutput("final_queue", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
